exec_stage_sequencer: RTL and testbench

// - Pipeline controller for the Vec_CPU Execute stage register: produces its enable and bubble-select.
// - Stalls Fetch/Decode on RAW hazards (no forwarding) and on memory-stage busy.
// - Holds the Execute register for VEC_BEATS cycles while a 64-bit vector op runs on the shared lane ALU.
// - Sits between Decode and the Execute register; lane_sel drives the lane ALU beat index.

---
 rtl/vec_cpu_pkg.sv | 7 +
 rtl/hazard_detect.sv | 20 ++
 rtl/exec_stage_sequencer.sv | 92 +++++++++
 tb/tb_exec_stage_sequencer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/vec_cpu_pkg.sv
// vec_cpu_pkg: shared types and constants for the Vec_CPU pipeline control blocks.
package vec_cpu_pkg;
    localparam int REG_IDX_W = 3;
    localparam logic [4:0] NOP_OPCODE = 5'b11110;
    localparam int DEF_VEC_BEATS = 4;
    typedef enum logic {S_RUN, S_VEC} seq_state_t;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: flags a RAW hazard when a Decode source matches a pending Execute/Memory writeback.
module hazard_detect
    import vec_cpu_pkg::*;
(
    input  logic                 d_valid,
    input  logic                 d_src1_en,
    input  logic [REG_IDX_W-1:0] d_src1,
    input  logic                 d_src2_en,
    input  logic [REG_IDX_W-1:0] d_src2,
    input  logic                 ex_wb_en,
    input  logic [REG_IDX_W-1:0] ex_wb_register,
    input  logic                 mem_wb_en,
    input  logic [REG_IDX_W-1:0] mem_wb_register,
    output logic                 hazard
);
    logic src1_hit, src2_hit;
    assign src1_hit = (ex_wb_en && d_src1 == ex_wb_register) || (mem_wb_en && d_src1 == mem_wb_register);
    assign src2_hit = (ex_wb_en && d_src2 == ex_wb_register) || (mem_wb_en && d_src2 == mem_wb_register);
    assign hazard = d_valid && ((d_src1_en && src1_hit) || (d_src2_en && src2_hit));
endmodule

// File: rtl/exec_stage_sequencer.sv
// exec_stage_sequencer: Execute-register enable/bubble control with RAW stalls,
// memory back-pressure and multi-beat vector holds on the shared lane ALU.
module exec_stage_sequencer
    import vec_cpu_pkg::*;
#(
    parameter int VEC_BEATS = DEF_VEC_BEATS,
    parameter int BEAT_W    = $clog2(VEC_BEATS),
    parameter int CNT_W     = 16
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 d_valid,
    input  logic                 d_is_vec,
    input  logic                 d_src1_en,
    input  logic [REG_IDX_W-1:0] d_src1,
    input  logic                 d_src2_en,
    input  logic [REG_IDX_W-1:0] d_src2,
    input  logic                 ex_wb_en,
    input  logic [REG_IDX_W-1:0] ex_wb_register,
    input  logic                 mem_wb_en,
    input  logic [REG_IDX_W-1:0] mem_wb_register,
    input  logic                 mem_busy,
    output logic                 fetch_en,
    output logic                 decode_en,
    output logic                 ex_en,
    output logic                 ex_bubble,
    output logic [BEAT_W-1:0]    lane_sel,
    output logic                 vec_last,
    output logic [CNT_W-1:0]     bubble_count
);
    seq_state_t state, state_nx;
    logic [BEAT_W-1:0] beat, beat_nx;
    logic [CNT_W-1:0] cnt_nx;
    logic hazard, last_beat, holding;

    hazard_detect u_hazard (
        .d_valid(d_valid), .d_src1_en(d_src1_en), .d_src1(d_src1),
        .d_src2_en(d_src2_en), .d_src2(d_src2),
        .ex_wb_en(ex_wb_en), .ex_wb_register(ex_wb_register),
        .mem_wb_en(mem_wb_en), .mem_wb_register(mem_wb_register),
        .hazard(hazard)
    );

    assign last_beat = beat == BEAT_W'(VEC_BEATS - 1);
    assign holding   = state == S_VEC && !last_beat;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state        <= S_RUN;
            beat         <= '0;
            bubble_count <= '0;
        end else begin
            state        <= state_nx;
            beat         <= beat_nx;
            bubble_count <= cnt_nx;
        end

    // The last vector beat doubles as the next issue slot, so back-to-back ops need no gap.
    always_comb begin
        state_nx  = state;
        beat_nx   = beat;
        cnt_nx    = bubble_count;
        fetch_en  = 1'b0;
        decode_en = 1'b0;
        ex_en     = 1'b0;
        ex_bubble = 1'b0;
        lane_sel  = state == S_VEC ? beat : '0;
        vec_last  = state == S_VEC && last_beat;
        if (!reset) begin
            ex_en     = 1'b1;
            ex_bubble = 1'b1;
            lane_sel  = '0;
            vec_last  = 1'b0;
        end else if (mem_busy) begin
        end else if (holding) begin
            beat_nx = beat + 1'b1;
        end else if (hazard) begin
            ex_en     = 1'b1;
            ex_bubble = 1'b1;
            cnt_nx    = &bubble_count ? bubble_count : bubble_count + 1'b1;
            state_nx  = S_RUN;
            beat_nx   = '0;
        end else begin
            fetch_en  = 1'b1;
            decode_en = 1'b1;
            ex_en     = 1'b1;
            ex_bubble = !d_valid;
            state_nx  = d_valid && d_is_vec ? S_VEC : S_RUN;
            beat_nx   = '0;
        end
    end
endmodule

// File: tb/tb_exec_stage_sequencer.sv
// tb_exec_stage_sequencer: directed vector table, counter saturation run and
// randomized traffic against a cycle-level behavioural model.
module tb_exec_stage_sequencer;
    localparam int VB = 4;

    logic clk = 0, reset = 0;
    logic d_valid = 0, d_is_vec = 0, d_src1_en = 0, d_src2_en = 0;
    logic [2:0] d_src1 = 0, d_src2 = 0, ex_wb_register = 0, mem_wb_register = 0;
    logic ex_wb_en = 0, mem_wb_en = 0, mem_busy = 0;
    logic fetch_en, decode_en, ex_en, ex_bubble, vec_last;
    logic [1:0] lane_sel;
    logic [15:0] bubble_count;

    always #5 clk = ~clk;

    exec_stage_sequencer dut (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_is_vec(d_is_vec),
        .d_src1_en(d_src1_en), .d_src1(d_src1), .d_src2_en(d_src2_en), .d_src2(d_src2),
        .ex_wb_en(ex_wb_en), .ex_wb_register(ex_wb_register),
        .mem_wb_en(mem_wb_en), .mem_wb_register(mem_wb_register), .mem_busy(mem_busy),
        .fetch_en(fetch_en), .decode_en(decode_en), .ex_en(ex_en), .ex_bubble(ex_bubble),
        .lane_sel(lane_sel), .vec_last(vec_last), .bubble_count(bubble_count)
    );

    typedef struct {
        logic rst_n, dv, vec, s1e; logic [2:0] s1; logic s2e; logic [2:0] s2;
        logic exe; logic [2:0] exr; logic meme; logic [2:0] memr; logic busy;
        int fe, de, ee, bub, lane, last, cnt;
    } vec_t;

    int n_cmp = 0, n_bad = 0;
    vec_t tbl[$];

    function automatic vec_t v(int rst_n, int dv, int vec, int s1e, int s1, int s2e, int s2,
                               int exe, int exr, int meme, int memr, int busy,
                               int fe, int de, int ee, int bub, int lane, int last, int cnt);
        vec_t r;
        r.rst_n = rst_n[0]; r.dv = dv[0]; r.vec = vec[0]; r.s1e = s1e[0]; r.s1 = s1[2:0];
        r.s2e = s2e[0]; r.s2 = s2[2:0]; r.exe = exe[0]; r.exr = exr[2:0];
        r.meme = meme[0]; r.memr = memr[2:0]; r.busy = busy[0];
        r.fe = fe; r.de = de; r.ee = ee; r.bub = bub; r.lane = lane; r.last = last; r.cnt = cnt;
        return r;
    endfunction

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(string tag, int fe, int de, int ee, int bub, int lane, int last, int cnt);
        check({tag, " fetch_en"}, int'(fetch_en), fe);
        check({tag, " decode_en"}, int'(decode_en), de);
        check({tag, " ex_en"}, int'(ex_en), ee);
        check({tag, " ex_bubble"}, int'(ex_bubble), bub);
        check({tag, " lane_sel"}, int'(lane_sel), lane);
        check({tag, " vec_last"}, int'(vec_last), last);
        check({tag, " bubble_count"}, int'(bubble_count), cnt);
    endtask

    task automatic apply(vec_t r, int idx);
        reset = r.rst_n; d_valid = r.dv; d_is_vec = r.vec; d_src1_en = r.s1e; d_src1 = r.s1;
        d_src2_en = r.s2e; d_src2 = r.s2; ex_wb_en = r.exe; ex_wb_register = r.exr;
        mem_wb_en = r.meme; mem_wb_register = r.memr; mem_busy = r.busy;
        @(negedge clk);
        check_all($sformatf("row%0d", idx), r.fe, r.de, r.ee, r.bub, r.lane, r.last, r.cnt);
        @(posedge clk); #1;
    endtask

    // Behavioural model: tracks how many cycles the current vector op has occupied Execute.
    bit m_vec;
    int m_pos, m_cnt;

    function automatic bit pending_write(logic [2:0] r);
        return (ex_wb_en && r == ex_wb_register) || (mem_wb_en && r == mem_wb_register);
    endfunction

    task automatic model_step(int cyc);
        bit haz;
        int fe, de, ee, bub, lane, last, cnt;
        if (!reset) begin m_vec = 0; m_pos = 0; m_cnt = 0; end
        haz = d_valid && ((d_src1_en && pending_write(d_src1)) || (d_src2_en && pending_write(d_src2)));
        lane = m_vec ? m_pos : 0;
        last = (m_vec && m_pos == VB - 1) ? 1 : 0;
        cnt = m_cnt;
        {fe, de, ee, bub} = '0;
        if (!reset) begin
            ee = 1; bub = 1; lane = 0; last = 0;
        end else if (mem_busy) begin
        end else if (m_vec && m_pos < VB - 1) begin
            m_pos++;
        end else if (haz) begin
            ee = 1; bub = 1;
            m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
            m_vec = 0;
        end else begin
            fe = 1; de = 1; ee = 1; bub = d_valid ? 0 : 1;
            m_vec = d_valid && d_is_vec;
            m_pos = 0;
        end
        check_all($sformatf("rand%0d", cyc), fe, de, ee, bub, lane, last, cnt);
    endtask

    initial begin
        // rst dv vec s1e s1 s2e s2 exe exr meme memr busy | fe de ee bub lane last cnt
        repeat (3) tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,1,1,0,0,0));
        tbl.push_back(v(1,1,0,1,1,1,2,1,3,1,4,0, 1,1,1,0,0,0,0));
        tbl.push_back(v(1,1,0,1,5,1,6,1,7,1,0,0, 1,1,1,0,0,0,0));
        tbl.push_back(v(1,0,0,1,3,0,0,1,3,0,0,0, 1,1,1,1,0,0,0));
        tbl.push_back(v(1,1,0,1,3,0,0,1,3,0,0,0, 0,0,1,1,0,0,0));
        tbl.push_back(v(1,1,0,1,3,0,0,0,3,1,3,0, 0,0,1,1,0,0,1));
        tbl.push_back(v(1,1,0,1,3,0,0,1,2,1,4,0, 1,1,1,0,0,0,2));
        tbl.push_back(v(1,1,0,0,0,0,5,1,5,0,0,0, 1,1,1,0,0,0,2));
        tbl.push_back(v(1,1,1,1,1,0,0,1,2,1,2,0, 1,1,1,0,0,0,2));
        tbl.push_back(v(1,1,1,1,1,0,0,0,0,0,0,0, 0,0,0,0,0,0,2));
        tbl.push_back(v(1,1,1,1,1,0,0,0,0,0,0,0, 0,0,0,0,1,0,2));
        tbl.push_back(v(1,1,1,1,1,0,0,0,0,0,0,0, 0,0,0,0,2,0,2));
        tbl.push_back(v(1,1,1,1,1,0,0,0,0,0,0,0, 1,1,1,0,3,1,2));
        tbl.push_back(v(1,1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,2));
        tbl.push_back(v(1,1,0,0,0,0,0,0,0,0,0,1, 0,0,0,0,1,0,2));
        tbl.push_back(v(1,1,0,0,0,0,0,0,0,0,0,1, 0,0,0,0,1,0,2));
        tbl.push_back(v(1,1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,1,0,2));
        tbl.push_back(v(1,1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,2,0,2));
        tbl.push_back(v(1,1,0,1,1,0,0,1,1,0,0,0, 0,0,1,1,3,1,2));
        tbl.push_back(v(1,0,0,0,0,0,0,0,0,0,0,0, 1,1,1,1,0,0,3));
        tbl.push_back(v(1,1,0,1,4,0,0,0,0,1,4,1, 0,0,0,0,0,0,3));
        tbl.push_back(v(1,1,0,1,4,0,0,0,0,1,4,0, 0,0,1,1,0,0,3));
        tbl.push_back(v(1,0,0,0,0,0,0,0,0,0,0,0, 1,1,1,1,0,0,4));
        tbl.push_back(v(1,1,1,0,0,0,0,0,0,0,0,0, 1,1,1,0,0,0,4));
        tbl.push_back(v(1,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,4));
        tbl.push_back(v(1,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,1,0,4));
        tbl.push_back(v(1,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,2,0,4));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,1,1,0,0,0));
        tbl.push_back(v(1,0,0,0,0,0,0,0,0,0,0,0, 1,1,1,1,0,0,0));
        foreach (tbl[i]) apply(tbl[i], i);

        // Saturation: hold a hazard for 65536 cycles; the counter must stick at all-ones.
        reset = 1; d_valid = 1; d_is_vec = 0; d_src1_en = 1; d_src1 = 6; d_src2_en = 0;
        ex_wb_en = 1; ex_wb_register = 6; mem_wb_en = 0; mem_busy = 0;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        check("sat 65534", int'(bubble_count), 16'hFFFE);
        @(negedge clk);
        check("sat 65535", int'(bubble_count), 16'hFFFF);
        @(negedge clk);
        check("sat hold", int'(bubble_count), 16'hFFFF);
        check("sat fetch_en", int'(fetch_en), 0);
        @(posedge clk); #1;

        for (int c = 0; c < 2000; c++) begin
            reset = (c == 0) ? 1'b0 : ($urandom_range(63) != 0);
            d_valid = $urandom_range(7) != 0;
            d_is_vec = $urandom_range(3) == 0;
            d_src1_en = $urandom_range(1); d_src1 = 3'($urandom_range(7));
            d_src2_en = $urandom_range(1); d_src2 = 3'($urandom_range(7));
            ex_wb_en = $urandom_range(1); ex_wb_register = 3'($urandom_range(7));
            mem_wb_en = $urandom_range(1); mem_wb_register = 3'($urandom_range(7));
            mem_busy = $urandom_range(4) == 0;
            @(negedge clk);
            model_step(c);
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
